// File: rtl/cdecv_pkg.sv
// rtl/cdecv_pkg.sv - shared ALU opcodes, flag indices and multiply sequencer states
package cdecv_pkg;

  // ALU opcodes used by the multiply sequencer
  localparam logic [3:0] ALUOP_PASS_A = 4'b0000;
  localparam logic [3:0] ALUOP_ADD    = 4'b1010;

  // Bit positions inside the ALU {S,Z,Cy} flag bus
  localparam int SZCY_CY = 0;
  localparam int SZCY_Z  = 1;
  localparam int SZCY_S  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/mul_seq.sv
// rtl/mul_seq.sv - 8x8 shift-and-add multiply sequencer driving the shared datapath ALU
module mul_seq
  import cdecv_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  op_a,
  input  logic [7:0]  op_b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product,
  output logic        prod_z,
  output logic [3:0]  alu_aluop,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic        alu_cy_in,
  input  logic [7:0]  alu_result,
  input  logic [2:0]  alu_szcy
);

  mul_state_e  state_q, state_d;
  logic [7:0]  acc_hi_q, acc_hi_d;
  logic [7:0]  mplier_q, mplier_d;
  logic [7:0]  mcand_q, mcand_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] product_q, product_d;

  // {Cy, result, mplier[7:1]}: the partial product shifted right by one after this iteration
  logic [15:0] shift_w;

  // S and Z are not needed for an unsigned multiply
  logic unused_flags;
  assign unused_flags = ^alu_szcy[SZCY_S:SZCY_Z];

  assign shift_w = {alu_szcy[SZCY_CY], alu_result, mplier_q[7:1]};

  // State register and datapath registers; reset clears everything so no partial product leaks
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      acc_hi_q  <= 8'h00;
      mplier_q  <= 8'h00;
      mcand_q   <= 8'h00;
      cnt_q     <= 3'd0;
      product_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      acc_hi_q  <= acc_hi_d;
      mplier_q  <= mplier_d;
      mcand_q   <= mcand_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  // Next-state: accept start in IDLE/DONE, iterate eight times in RUN, publish product on the DONE edge
  always_comb begin
    state_d   = state_q;
    acc_hi_d  = acc_hi_q;
    mplier_d  = mplier_q;
    mcand_d   = mcand_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d  = ST_RUN;
          acc_hi_d = 8'h00;
          mplier_d = op_b;
          mcand_d  = op_a;
          cnt_d    = 3'd0;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_RUN: begin
        acc_hi_d = shift_w[15:8];
        mplier_d = shift_w[7:0];
        cnt_d    = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d   = ST_DONE;
          product_d = shift_w;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ALU drive: add the multiplicand when the current multiplier bit is set, bus quiet outside RUN
  always_comb begin
    alu_aluop = ALUOP_PASS_A;
    alu_a     = 8'h00;
    alu_b     = 8'h00;
    alu_cy_in = 1'b0;
    if (state_q == ST_RUN) begin
      alu_aluop = mplier_q[0] ? ALUOP_ADD : ALUOP_PASS_A;
      alu_a     = acc_hi_q;
      alu_b     = mcand_q;
    end
  end

  assign busy    = (state_q == ST_RUN);
  assign done    = (state_q == ST_DONE);
  assign product = product_q;
  assign prod_z  = (product_q == 16'h0000);

endmodule

// File: tb/tb_mul_seq.sv
// tb/tb_mul_seq.sv - scoreboard bench for mul_seq with a behavioural ALU and multiply model
module tb_mul_seq;
  import cdecv_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  op_a = 8'h00;
  logic [7:0]  op_b = 8'h00;
  logic        busy, done, prod_z, alu_cy_in;
  logic [15:0] product;
  logic [3:0]  alu_aluop;
  logic [7:0]  alu_a, alu_b, alu_result;
  logic [2:0]  alu_szcy;
  logic [8:0]  alu_sum;

  mul_seq dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .product(product), .prod_z(prod_z),
    .alu_aluop(alu_aluop), .alu_a(alu_a), .alu_b(alu_b), .alu_cy_in(alu_cy_in),
    .alu_result(alu_result), .alu_szcy(alu_szcy)
  );

  always #5 clk = ~clk;

  // Environment ALU: a+b with carry, or pass a
  assign alu_sum    = {1'b0, alu_a} + {1'b0, alu_b};
  assign alu_result = (alu_aluop == ALUOP_ADD) ? alu_sum[7:0] : alu_a;
  assign alu_szcy   = {alu_result[7], alu_result == 8'h00,
                       (alu_aluop == ALUOP_ADD) ? alu_sum[8] : 1'b0};

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
    int          dcyc;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_bad = 0;
  int          iter = 0;
  logic [15:0] held = 16'h0000;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    op_a = a; op_b = b; start = 1'b1;
    e.a = a; e.b = b; e.p = 16'(int'(a) * int'(b)); e.dcyc = cyc + 9;
    sb.push_back(e);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while (sb.size() != 0 && n < bound) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      check("done_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  // Monitor: checks the ALU drive against the ideal partial product and pops results on done
  always @(negedge clk) begin
    exp_t        e;
    int          mask;
    int          pp;
    logic [7:0]  ea;
    logic [3:0]  eop;
    if (!reset_n) begin
      iter = 0;
      held = 16'h0000;
    end else begin
      check("alu_cy_in", 32'(alu_cy_in), 32'd0);
      if (busy) begin
        if (sb.size() == 0 || iter > 7) begin
          check("busy_unexpected", 32'(iter), 32'hFFFF);
        end else begin
          e    = sb[0];
          mask = (1 << iter) - 1;
          pp   = (int'(e.a) * (int'(e.b) & mask)) >> iter;
          ea   = pp[7:0];
          eop  = e.b[iter[2:0]] ? ALUOP_ADD : ALUOP_PASS_A;
          check("run_aluop", 32'(alu_aluop), 32'(eop));
          check("run_alu_a", 32'(alu_a), 32'(ea));
          check("run_alu_b", 32'(alu_b), 32'(e.a));
          check("run_done_low", 32'(done), 32'd0);
          check("run_product_held", 32'(product), 32'(held));
        end
        iter++;
      end else begin
        iter = 0;
        check("quiet_bus", {20'd0, alu_aluop, alu_a | alu_b}, 32'd0);
        if (done) begin
          if (sb.size() == 0) begin
            check("done_unexpected", 32'(done), 32'd0);
          end else begin
            e = sb.pop_front();
            check("product", 32'(product), 32'(e.p));
            check("prod_z", 32'(prod_z), 32'(e.p == 16'h0000));
            check("done_cycle", 32'(cyc), 32'(e.dcyc));
            held = e.p;
          end
        end else begin
          check("idle_product_held", 32'(product), 32'(held));
          check("idle_prod_z", 32'(prod_z), 32'(held == 16'h0000));
        end
      end
    end
  end

  initial begin
    int k;
    reset_n = 1'b0;
    tick(); tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_product", 32'(product), 32'd0);
    check("rst_prod_z", 32'(prod_z), 32'd1);
    check("rst_alu", {20'd0, alu_aluop, alu_a | alu_b}, 32'd0);
    reset_n = 1'b1;
    tick();

    issue(8'd13, 8'd11);   wait_idle(20);
    issue(8'd255, 8'd255); wait_idle(20);
    issue(8'h5A, 8'd0);    wait_idle(20);
    issue(8'd0, 8'd77);    wait_idle(20);

    // start re-pulsed with new operands in RUN cycle 4 must be ignored
    issue(8'd37, 8'd201);
    tick(); tick(); tick();
    op_a = 8'd99; op_b = 8'd88; start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle(20);

    // reset in RUN cycle 5 aborts immediately
    issue(8'd200, 8'd150);
    tick(); tick(); tick(); tick();
    reset_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_product", 32'(product), 32'd0);
    check("abort_prod_z", 32'(prod_z), 32'd1);
    check("abort_alu", {20'd0, alu_aluop, alu_a | alu_b}, 32'd0);
    sb.delete();
    tick();
    reset_n = 1'b1;
    tick();
    issue(8'd171, 8'd205); wait_idle(20);

    // start held high: one product every 9 cycles
    op_a = 8'd3; op_b = 8'd7; start = 1'b1;
    k = cyc;
    for (int i = 1; i <= 3; i++) begin
      exp_t e;
      e.a = 8'd3; e.b = 8'd7; e.p = 16'd21; e.dcyc = k + 9 * i;
      sb.push_back(e);
    end
    while (cyc < k + 20) tick();
    start = 1'b0;
    wait_idle(40);

    // randomized operands with random idle gaps
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      issue(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      wait_idle(20);
    end

    tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
